operand_entry: RTL and testbench

- Sequential input front-end for the ALU lab board.
- Builds the 10-bit operand word {left[4:0], right[4:0]} from five slide switches and an ENTER push-button. The operand is entered in two steps: left first, then right.
- Drives the same `operands` bus that the display/operation blocks consume. It also flags when a complete operand pair is ready.
- Raw buttons and switches are asynchronous to `clk`. This block synchronises them, and debounces the buttons.

---
 rtl/operand_entry.sv | 162 ++++++++++++++++
 tb/tb_operand_entry.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry
//  Description : Two-step operand entry front-end. Synchronises the slide
//                switches and buttons, debounces ENTER/CLEAR, and assembles
//                the {left, right} operand word with ready/valid status.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] switches,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [9:0] operands,
    output logic       operands_ready,
    output logic       operands_valid,
    output logic [1:0] entry_state
);

    // Terminal count: the level is accepted on the DEBOUNCE_CYCLES-th
    // consecutive cycle of disagreement.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LEFT  = 2'b00,
        ST_WAIT_RIGHT = 2'b01,
        ST_DONE       = 2'b10
    } state_t;

    logic [4:0] r_sw_s1;
    logic [4:0] r_sw_s2;
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_enter_press;
    logic       w_clear_press;

    state_t     r_state;
    logic [4:0] r_left;
    logic [4:0] r_right;
    logic       r_ready;
    logic       r_valid;

    // Bit 0 is ENTER, bit 1 is CLEAR; both share the same conditioning chain.
    assign w_btn_raw     = {btn_clear, btn_enter};
    assign w_enter_press = w_press[0];
    assign w_clear_press = w_press[1];

    // Two-flop synchroniser for the switch bank (no debounce on switches).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_s1 <= 5'd0;
            r_sw_s2 <= 5'd0;
        end else begin
            r_sw_s1 <= switches;
            r_sw_s2 <= r_sw_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             r_s1;
            logic             r_s2;
            logic             r_db;
            logic             r_db_q;
            logic [CNT_W-1:0] r_cnt;

            // Two-flop synchroniser for the raw button.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_btn_raw[gi];
                    r_s2 <= r_s1;
                end
            end

            // Accept a new level only after it has disagreed with the
            // debounced level for DEBOUNCE_CYCLES consecutive cycles.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_db  <= 1'b0;
                    r_cnt <= '0;
                end else if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end

            // Delayed copy of the debounced level for rising-edge detection.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_db_q <= 1'b0;
                end else begin
                    r_db_q <= r_db;
                end
            end

            // One-cycle pulse per accepted press; releases and holds give nothing.
            assign w_press[gi] = r_db & ~r_db_q;
        end
    endgenerate

    // Entry sequencer: left then right; CLEAR overrides a simultaneous ENTER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_LEFT;
            r_left  <= 5'd0;
            r_right <= 5'd0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_clear_press) begin
                r_state <= ST_WAIT_LEFT;
                r_left  <= 5'd0;
                r_right <= 5'd0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_LEFT, ST_DONE: begin
                        // Starting a new pair from DONE behaves like a fresh left entry.
                        if (w_enter_press) begin
                            r_state <= ST_WAIT_RIGHT;
                            r_left  <= r_sw_s2;
                            r_right <= 5'd0;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_WAIT_RIGHT: begin
                        if (w_enter_press) begin
                            r_state <= ST_DONE;
                            r_right <= r_sw_s2;
                            r_ready <= 1'b1;
                            r_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_LEFT;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign operands       = {r_left, r_right};
    assign operands_ready = r_ready;
    assign operands_valid = r_valid;
    assign entry_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_entry
//  Description : Self-checking bench for operand_entry (DEBOUNCE_CYCLES = 4).
//                Directed scenarios with literal expectations, followed by
//                randomized button/switch activity against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

    localparam int D = 4;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [4:0] switches  = 5'd0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [9:0] operands;
    logic       operands_ready;
    logic       operands_valid;
    logic [1:0] entry_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_valid   = 0;
    int n_changes = 0;
    bit cmp_en    = 1'b0;

    operand_entry #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switches(switches),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .operands(operands),
        .operands_ready(operands_ready),
        .operands_valid(operands_valid),
        .entry_state(entry_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A button level is accepted once the last D
    // synchronised samples all disagree with the current accepted level;
    // the resulting press acts on the FSM one edge later. Switches are
    // seen with the same two-sample delay as the buttons.
    // ------------------------------------------------------------------
    logic [1:0]   m_st;
    logic [4:0]   m_left, m_right;
    logic         m_ready, m_valid;
    logic [1:0]   m_h0, m_h1;
    logic [4:0]   m_sw0, m_sw1;
    logic [D-1:0] m_win [2];
    logic [1:0]   m_db;
    logic [1:0]   m_press;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_st = 2'd0; m_left = 5'd0; m_right = 5'd0;
                m_ready = 1'b0; m_valid = 1'b0;
                m_h0 = 2'd0; m_h1 = 2'd0; m_sw0 = 5'd0; m_sw1 = 5'd0;
                m_win[0] = '0; m_win[1] = '0; m_db = 2'd0; m_press = 2'd0;
            end else begin
                m_valid = 1'b0;
                if (m_press[1]) begin
                    m_st = 2'd0; m_left = 5'd0; m_right = 5'd0;
                end else if (m_press[0]) begin
                    if (m_st == 2'd1) begin
                        m_right = m_sw1; m_st = 2'd2; m_valid = 1'b1;
                    end else begin
                        m_left = m_sw1; m_right = 5'd0; m_st = 2'd1;
                    end
                end
                m_ready = (m_st == 2'd2);
                for (int b = 0; b < 2; b++) begin
                    m_win[b] = {m_win[b][D-2:0], m_h1[b]};
                    m_press[b] = 1'b0;
                    if (m_win[b] == {D{~m_db[b]}}) begin
                        m_db[b]    = ~m_db[b];
                        m_press[b] = m_db[b];
                    end
                end
                m_h1  = m_h0;  m_h0  = {btn_clear, btn_enter};
                m_sw1 = m_sw0; m_sw0 = switches;
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse/transition tallies.
    logic [1:0] prev_st = 2'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !reset) begin
                chk("model_operands", operands, {m_left, m_right});
                chk("model_ready", {9'd0, operands_ready}, {9'd0, m_ready});
                chk("model_valid", {9'd0, operands_valid}, {9'd0, m_valid});
                chk("model_state", {8'd0, entry_state}, {8'd0, m_st});
                if (operands_valid) n_valid++;
                if (entry_state != prev_st) n_changes++;
                prev_st = entry_state;
            end else begin
                prev_st = 2'd0;
            end
        end
    end

    task automatic press(input int which, input int hold);
        if (which == 0) btn_enter = 1'b1; else btn_clear = 1'b1;
        repeat (hold) @(negedge clk);
        if (which == 0) btn_enter = 1'b0; else btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int v0, c0, he, hc;
        bit adv;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("reset_operands", operands, 10'd0);
        chk("reset_ready", {9'd0, operands_ready}, 10'd0);
        chk("reset_valid", {9'd0, operands_valid}, 10'd0);
        chk("reset_state", {8'd0, entry_state}, 10'd0);

        // Basic entry
        switches = 5'b01010; press(0, 10);
        chk("t1_left_state", {8'd0, entry_state}, 10'd1);
        switches = 5'b10000; v0 = n_valid; press(0, 10);
        chk("t1_operands", operands, 10'b01010_10000);
        chk("t1_ready", {9'd0, operands_ready}, 10'd1);
        chk("t1_state", {8'd0, entry_state}, 10'd2);
        chk("t1_valid_pulses", 10'(n_valid - v0), 10'd1);

        // Re-entry from DONE
        switches = 5'b11111; press(0, 10);
        chk("t4_operands", operands, 10'b11111_00000);
        chk("t4_state", {8'd0, entry_state}, 10'd1);
        chk("t4_ready", {9'd0, operands_ready}, 10'd0);
        press(1, 10);
        chk("clear_state", {8'd0, entry_state}, 10'd0);

        // Bounce rejection then a clean settle
        adv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_enter = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (entry_state != 2'd0) adv = 1'b1;
            end
        end
        chk("t2_no_adv_bounce", {9'd0, adv}, 10'd0);
        btn_enter = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2_before_7", {8'd0, entry_state}, 10'd0);
        @(negedge clk);
        chk("t2_at_7", {8'd0, entry_state}, 10'd1);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_single_adv", {8'd0, entry_state}, 10'd1);
        press(1, 10);

        // Hold in WAIT_LEFT
        switches = 5'b01101; c0 = n_changes; btn_enter = 1'b1;
        repeat (100) @(negedge clk);
        chk("t3_state", {8'd0, entry_state}, 10'd1);
        chk("t3_transitions", 10'(n_changes - c0), 10'd1);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_left", operands, 10'b01101_00000);

        // Clear wins over a coincident enter
        v0 = n_valid; btn_enter = 1'b1; btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_state", {8'd0, entry_state}, 10'd0);
        chk("t5_operands", operands, 10'd0);
        chk("t5_no_valid", 10'(n_valid - v0), 10'd0);

        // Asynchronous reset while in DONE
        switches = 5'b00111; press(0, 10);
        switches = 5'b11001; press(0, 10);
        chk("t6_operands", operands, 10'b00111_11001);
        chk("t6_state", {8'd0, entry_state}, 10'd2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_operands", operands, 10'd0);
        chk("t6_async_ready", {9'd0, operands_ready}, 10'd0);
        chk("t6_async_valid", {9'd0, operands_valid}, 10'd0);
        chk("t6_async_state", {8'd0, entry_state}, 10'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized activity, checked every cycle against the model
        he = 0; hc = 0;
        repeat (3000) begin
            @(negedge clk);
            if (he == 0) begin
                btn_enter = 1'($urandom_range(0, 1));
                he = $urandom_range(1, 12);
            end else begin
                he--;
            end
            if (hc == 0) begin
                btn_clear = ($urandom_range(0, 4) == 0);
                hc = $urandom_range(1, 12);
            end else begin
                hc--;
            end
            if ($urandom_range(0, 3) == 0) switches = 5'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
